// File: rtl/can_reg_write_demux_if.sv
// can_reg_write_demux_if: host single-beat write bus (request, address, data, acknowledge)
interface can_reg_write_demux_if;
  logic        Controller2Demux_CS;
  logic [7:0]  addr_bus1;
  logic [31:0] data_bus1;
  logic        Demux2Controller_ack;
  modport master (output Controller2Demux_CS, output addr_bus1, output data_bus1, input Demux2Controller_ack);
  modport slave (input Controller2Demux_CS, input addr_bus1, input data_bus1, output Demux2Controller_ack);
endinterface

// File: rtl/can_reg_write_demux.sv
// can_reg_write_demux: decodes host writes into CAN config registers and TX frame words; define CAN_TXFRAME_ASSEMBLY_EN to push only fully staged frames
module can_reg_write_demux (
  input  logic                 sys_clk,
  input  logic                 IP2Can_reset_n,
  can_reg_write_demux_if.slave bus,
  input  logic                 txfifo_full,
  output logic [31:0]          srr_reg,
  output logic [31:0]          msr_reg,
  output logic [31:0]          brpr_reg,
  output logic [31:0]          btr_reg,
  output logic [31:0]          ier_reg,
  output logic [31:0]          icr_pulse,
  output logic [31:0]          txfifo_id,
  output logic [31:0]          txfifo_dlc,
  output logic [31:0]          txfifo_dw1,
  output logic [31:0]          txfifo_dw2,
  output logic                 txfifo_push,
  output logic                 wr_err
);
  typedef enum logic [2:0] {IDLE, DECODE, PUSH, ACK, RELEASE} state_t;
  state_t      state_q, state_d;
  logic [7:0]  addr_q;
  logic [31:0] data_q, srr_q, msr_q, brpr_q, btr_q, ier_q, icr_q, id_q, dlc_q, dw1_q, dw2_q;
  logic        err_q, wr, soft_rst, hit_dw2, mapped, locked, push_ok, bad, pushing;
  assign wr       = state_q == DECODE;
  assign soft_rst = wr && addr_q == 8'h00 && data_q[0];
  assign hit_dw2  = addr_q == 8'h3C;
  assign mapped   = addr_q inside {8'h00, 8'h04, 8'h08, 8'h0C, 8'h20, 8'h24, 8'h30, 8'h34, 8'h38, 8'h3C};
  assign locked   = srr_q[1] && (addr_q == 8'h08 || addr_q == 8'h0C);
  assign bad      = !mapped || locked || (hit_dw2 && !push_ok);
  assign pushing  = state_q == PUSH && !txfifo_full;
`ifdef CAN_TXFRAME_ASSEMBLY_EN
  logic [3:0] mask_q;
  assign push_ok = &mask_q[2:0];
  // remember which staging words were written since the last push
  always_ff @(posedge sys_clk or negedge IP2Can_reset_n)
    if (!IP2Can_reset_n) mask_q <= '0;
    else if (soft_rst || pushing) mask_q <= '0;
    else if (wr && addr_q inside {8'h30, 8'h34, 8'h38, 8'h3C}) mask_q[addr_q[3:2]] <= 1'b1;
`else
  assign push_ok = 1'b1;
`endif
  // latch the request on CS and advance the write FSM
  always_ff @(posedge sys_clk or negedge IP2Can_reset_n)
    if (!IP2Can_reset_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && bus.Controller2Demux_CS) begin
        addr_q <= bus.addr_bus1;
        data_q <= bus.data_bus1;
      end
    end
  // next state: one write per CS assertion, push may stall on a full FIFO
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = bus.Controller2Demux_CS ? DECODE : IDLE;
      DECODE:  state_d = (hit_dw2 && push_ok) ? PUSH : ACK;
      PUSH:    state_d = txfifo_full ? PUSH : ACK;
      ACK:     state_d = RELEASE;
      RELEASE: state_d = bus.Controller2Demux_CS ? RELEASE : IDLE;
      default: state_d = IDLE;
    endcase
  end
  // configuration registers; BRPR/BTR are frozen while CEN is set
  always_ff @(posedge sys_clk or negedge IP2Can_reset_n)
    if (!IP2Can_reset_n) begin
      srr_q  <= '0;
      msr_q  <= '0;
      brpr_q <= '0;
      btr_q  <= '0;
      ier_q  <= '0;
    end else if (wr) begin
      if (soft_rst) begin
        msr_q  <= '0;
        brpr_q <= '0;
        btr_q  <= '0;
        ier_q  <= '0;
      end
      case (addr_q)
        8'h00: srr_q <= {data_q[31:1], 1'b0};
        8'h04: msr_q <= data_q;
        8'h08: brpr_q <= srr_q[1] ? brpr_q : data_q;
        8'h0C: btr_q <= srr_q[1] ? btr_q : data_q;
        8'h20: ier_q <= data_q;
        default: ;
      endcase
    end
  // TX frame staging words
  always_ff @(posedge sys_clk or negedge IP2Can_reset_n)
    if (!IP2Can_reset_n) begin
      id_q  <= '0;
      dlc_q <= '0;
      dw1_q <= '0;
      dw2_q <= '0;
    end else if (soft_rst) begin
      id_q  <= '0;
      dlc_q <= '0;
      dw1_q <= '0;
      dw2_q <= '0;
    end else if (wr) begin
      case (addr_q)
        8'h30: id_q <= data_q;
        8'h34: dlc_q <= data_q;
        8'h38: dw1_q <= data_q;
        8'h3C: dw2_q <= data_q;
        default: ;
      endcase
    end
  // interrupt clear is a single-cycle pulse following the decode cycle
  always_ff @(posedge sys_clk or negedge IP2Can_reset_n)
    if (!IP2Can_reset_n) icr_q <= '0;
    else icr_q <= (wr && addr_q == 8'h24) ? data_q : '0;
  // sticky error for rejected writes, cleared only by a soft reset
  always_ff @(posedge sys_clk or negedge IP2Can_reset_n)
    if (!IP2Can_reset_n) err_q <= 1'b0;
    else if (soft_rst) err_q <= 1'b0;
    else if (wr && bad) err_q <= 1'b1;
  assign bus.Demux2Controller_ack = state_q == ACK;
  assign txfifo_push = pushing;
  assign srr_reg     = srr_q;
  assign msr_reg     = msr_q;
  assign brpr_reg    = brpr_q;
  assign btr_reg     = btr_q;
  assign ier_reg     = ier_q;
  assign icr_pulse   = icr_q;
  assign txfifo_id   = id_q;
  assign txfifo_dlc  = dlc_q;
  assign txfifo_dw1  = dw1_q;
  assign txfifo_dw2  = dw2_q;
  assign wr_err      = err_q;
endmodule

// File: tb/tb_can_reg_write_demux.sv
// tb_can_reg_write_demux: directed writes checked against a reference register model and a latency scoreboard
module tb_can_reg_write_demux;
  logic clk = 1'b0, rst_n = 1'b0, full = 1'b0;
  logic [31:0] srr, msr, brpr, btr, ier, icr, id, dlc, dw1, dw2;
  logic push, err;
  int errors = 0, checks = 0;
  typedef struct {
    string       tag;
    int          ack_lat;
    int          push_lat;
    int          pushes;
    int          icr_hits;
    logic [31:0] icr_val;
  } exp_t;
  exp_t sb[$];
  logic [31:0] m_srr, m_msr, m_brpr, m_btr, m_ier, m_id, m_dlc, m_dw1, m_dw2;
  logic        m_err;
  logic [3:0]  m_mask;
`ifdef CAN_TXFRAME_ASSEMBLY_EN
  localparam bit ASM = 1'b1;
`else
  localparam bit ASM = 1'b0;
`endif
  always #5 clk = ~clk;
  can_reg_write_demux_if bus ();
  can_reg_write_demux dut (
    .sys_clk(clk), .IP2Can_reset_n(rst_n), .bus(bus), .txfifo_full(full),
    .srr_reg(srr), .msr_reg(msr), .brpr_reg(brpr), .btr_reg(btr), .ier_reg(ier),
    .icr_pulse(icr), .txfifo_id(id), .txfifo_dlc(dlc), .txfifo_dw1(dw1), .txfifo_dw2(dw2),
    .txfifo_push(push), .wr_err(err)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask
  task automatic model_reset();
    {m_srr, m_msr, m_brpr, m_btr, m_ier, m_id, m_dlc, m_dw1, m_dw2} = '0;
    m_err  = 1'b0;
    m_mask = 4'h0;
  endtask
  function automatic bit model_write(input logic [7:0] a, input logic [31:0] d);
    bit p = 1'b0;
    case (a)
      8'h00: begin
        m_srr = {d[31:1], 1'b0};
        if (d[0]) begin
          {m_msr, m_brpr, m_btr, m_ier, m_id, m_dlc, m_dw1, m_dw2} = '0;
          m_err  = 1'b0;
          m_mask = 4'h0;
        end
      end
      8'h04: m_msr = d;
      8'h08: if (m_srr[1]) m_err = 1'b1; else m_brpr = d;
      8'h0C: if (m_srr[1]) m_err = 1'b1; else m_btr = d;
      8'h20: m_ier = d;
      8'h24: ;
      8'h30: begin m_id = d;  m_mask[0] = 1'b1; end
      8'h34: begin m_dlc = d; m_mask[1] = 1'b1; end
      8'h38: begin m_dw1 = d; m_mask[2] = 1'b1; end
      8'h3C: begin
        m_dw2 = d;
        m_mask[3] = 1'b1;
        if (!ASM || m_mask == 4'hF) begin
          p = 1'b1;
          m_mask = 4'h0;
        end else m_err = 1'b1;
      end
      default: m_err = 1'b1;
    endcase
    return p;
  endfunction
  task automatic check_all(input string t);
    chk({t, ":srr"}, srr, m_srr);
    chk({t, ":msr"}, msr, m_msr);
    chk({t, ":brpr"}, brpr, m_brpr);
    chk({t, ":btr"}, btr, m_btr);
    chk({t, ":ier"}, ier, m_ier);
    chk({t, ":tx_id"}, id, m_id);
    chk({t, ":tx_dlc"}, dlc, m_dlc);
    chk({t, ":tx_dw1"}, dw1, m_dw1);
    chk({t, ":tx_dw2"}, dw2, m_dw2);
    chk({t, ":wr_err"}, {31'b0, err}, {31'b0, m_err});
  endtask
  task automatic wr(input string tag, input logic [7:0] a, input logic [31:0] d, input int full_cyc, input int hold);
    exp_t e, o;
    int c, acks, pushes, icr_hits, ack_lat, push_lat;
    logic [31:0] icr2, f_id, f_dlc, f_dw1, f_dw2;
    bit p;
    p = model_write(a, d);
    e.tag      = tag;
    e.push_lat = p ? (full_cyc > 0 ? full_cyc + 1 : 2) : 0;
    e.ack_lat  = p ? e.push_lat + 1 : 2;
    e.pushes   = p ? 1 : 0;
    e.icr_hits = (a == 8'h24 && d != 0) ? 1 : 0;
    e.icr_val  = (a == 8'h24) ? d : 32'h0;
    sb.push_back(e);
    @(negedge clk);
    bus.Controller2Demux_CS = 1'b1;
    bus.addr_bus1 = a;
    bus.data_bus1 = d;
    full = full_cyc > 0;
    {c, acks, pushes, icr_hits, ack_lat, push_lat} = '0;
    {icr2, f_id, f_dlc, f_dw1, f_dw2} = '0;
    while (c < 40 && (ack_lat == 0 || c < ack_lat + hold)) begin
      @(posedge clk);
      #1;
      c++;
      if (c > full_cyc) full = 1'b0;
      #1;
      if (c == 2) icr2 = icr;
      if (icr !== 32'h0) icr_hits++;
      if (push === 1'b1) begin
        pushes++;
        if (push_lat == 0) begin
          push_lat = c;
          {f_id, f_dlc, f_dw1, f_dw2} = {id, dlc, dw1, dw2};
        end
      end
      if (bus.Demux2Controller_ack === 1'b1) begin
        acks++;
        if (ack_lat == 0) ack_lat = c;
      end
    end
    full = 1'b0;
    @(negedge clk);
    bus.Controller2Demux_CS = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #2;
      if (bus.Demux2Controller_ack === 1'b1) acks++;
      if (push === 1'b1) pushes++;
      if (icr !== 32'h0) icr_hits++;
    end
    o = sb.pop_front();
    chk({o.tag, ":ack_latency"}, ack_lat, o.ack_lat);
    chk({o.tag, ":ack_count"}, acks, 1);
    chk({o.tag, ":push_count"}, pushes, o.pushes);
    chk({o.tag, ":push_latency"}, push_lat, o.push_lat);
    chk({o.tag, ":icr_cycles"}, icr_hits, o.icr_hits);
    chk({o.tag, ":icr_value"}, icr2, o.icr_val);
    if (p) begin
      chk({o.tag, ":frame_id"}, f_id, m_id);
      chk({o.tag, ":frame_dlc"}, f_dlc, m_dlc);
      chk({o.tag, ":frame_dw1"}, f_dw1, m_dw1);
      chk({o.tag, ":frame_dw2"}, f_dw2, m_dw2);
    end
    check_all(o.tag);
  endtask
  initial begin
    bus.Controller2Demux_CS = 1'b0;
    bus.addr_bus1 = 8'h0;
    bus.data_bus1 = 32'h0;
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check_all("reset");
    chk("reset:ack", {31'b0, bus.Demux2Controller_ack}, 32'h0);
    chk("reset:push", {31'b0, push}, 32'h0);
    chk("reset:icr", icr, 32'h0);
    wr("btr", 8'h0C, 32'h0000_1A2B, 0, 1);
    wr("msr", 8'h04, 32'h0000_0003, 0, 1);
    wr("ier", 8'h20, 32'h0000_0F0F, 0, 1);
    wr("brpr", 8'h08, 32'h0000_0011, 0, 1);
    wr("cen_on", 8'h00, 32'h0000_0002, 0, 1);
    wr("brpr_locked", 8'h08, 32'h0000_0055, 0, 1);
    wr("btr_locked", 8'h0C, 32'h0000_0077, 0, 1);
    wr("soft_rst", 8'h00, 32'h0000_0001, 0, 1);
    wr("tx_id", 8'h30, 32'h1234_0000, 0, 1);
    wr("tx_dlc", 8'h34, 32'h8000_0000, 0, 1);
    wr("tx_dw1", 8'h38, 32'hDEAD_BEEF, 0, 1);
    wr("tx_dw2", 8'h3C, 32'hCAFE_F00D, 0, 1);
    wr("bp_id", 8'h30, 32'h0ABC_0000, 0, 1);
    wr("bp_dlc", 8'h34, 32'h4000_0000, 0, 1);
    wr("bp_dw1", 8'h38, 32'h0102_0304, 0, 1);
    wr("bp_dw2", 8'h3C, 32'h0506_0708, 5, 1);
    wr("icr_hold", 8'h24, 32'h0000_0005, 0, 10);
    wr("unmapped", 8'h10, 32'hFFFF_FFFF, 0, 1);
    wr("soft_rst2", 8'h00, 32'h0000_0001, 0, 1);
    @(negedge clk);
    bus.Controller2Demux_CS = 1'b1;
    bus.addr_bus1 = 8'h04;
    bus.data_bus1 = 32'h0000_0077;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("abort:ack", {31'b0, bus.Demux2Controller_ack}, 32'h0);
    chk("abort:push", {31'b0, push}, 32'h0);
    bus.Controller2Demux_CS = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("abort:ack_after", {31'b0, bus.Demux2Controller_ack}, 32'h0);
    check_all("abort");
    wr("dw2_only", 8'h3C, 32'h0BAD_F00D, 0, 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
